// File: rtl/pe_net_if.sv
// pe_net_if: PE-side network interface for one mesh node.
// Buffers PE packets in an injection FIFO, feeds the router local input under
// its enable, and registers ejected packets back to the PE.
// Optional: define PE_NET_IF_STALL_CNT_EN to add o_stall_count (BLOCKED cycles).

package pe_net_if_pkg;
    typedef logic [31:0] packet_t;
endpackage

module pe_net_if
    import pe_net_if_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  packet_t          i_pe_data,
    input  logic             i_pe_data_val,
    output logic             o_pe_ready,
    output packet_t          o_net_data,
    output logic             o_net_data_val,
    input  logic [3:0]       i_net_en,
    input  packet_t          i_net_data,
    input  logic             i_net_data_val,
    output packet_t          o_rx_data,
    output logic             o_rx_data_val,
    output logic [CNT_W-1:0] o_tx_count,
    output logic [CNT_W-1:0] o_rx_count,
`ifdef PE_NET_IF_STALL_CNT_EN
    output logic [CNT_W-1:0] o_stall_count,
`endif
    output logic             o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, SEND, BLOCKED} state_t;

    state_t        state;
    packet_t       mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          pop;

    // Handshake decode: pop depends only on pre-edge count and enable, so a
    // packet written into an empty FIFO cannot leave in the same cycle.
    always_comb begin
        o_pe_ready = (count < DEPTH_C);
        push       = i_pe_data_val && o_pe_ready;
        pop        = (count != '0) && (i_net_en != 4'b0000);
        count_nxt  = count;
        if (push && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (!push && pop)
            count_nxt = count - (AW+1)'(1);
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= i_pe_data;
    end

    // Injection FSM, FIFO pointers, registered network outputs and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            o_net_data     <= '0;
            o_net_data_val <= 1'b0;
            o_tx_count     <= '0;
            o_overflow     <= 1'b0;
        end else begin
            count          <= count_nxt;
            o_net_data_val <= pop;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                o_net_data <= mem[rd_ptr];
                o_tx_count <= o_tx_count + CNT_W'(1);
            end
            if (i_pe_data_val && !o_pe_ready)
                o_overflow <= 1'b1;
            if (count_nxt == '0)
                state <= IDLE;
            else if (i_net_en != 4'b0000)
                state <= SEND;
            else
                state <= BLOCKED;
        end
    end

    // Ejection path: one-cycle register, never back-pressured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rx_data     <= '0;
            o_rx_data_val <= 1'b0;
            o_rx_count    <= '0;
        end else begin
            o_rx_data     <= i_net_data;
            o_rx_data_val <= i_net_data_val;
            if (i_net_data_val)
                o_rx_count <= o_rx_count + CNT_W'(1);
        end
    end

`ifdef PE_NET_IF_STALL_CNT_EN
    // Counts cycles spent waiting on a closed router enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            o_stall_count <= '0;
        else if (state == BLOCKED)
            o_stall_count <= o_stall_count + CNT_W'(1);
    end
`endif

    // IDLE is registered alongside count, so the two always agree.
    a_idle_empty: assert property (@(posedge clk) disable iff (!reset_n)
        (state == IDLE) == (count == '0));

endmodule

// File: tb/tb_pe_net_if.sv
module tb_pe_net_if;
    import pe_net_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    packet_t     i_pe_data = '0;
    logic        i_pe_data_val = 1'b0;
    logic        o_pe_ready;
    packet_t     o_net_data;
    logic        o_net_data_val;
    logic [3:0]  i_net_en = 4'b0000;
    packet_t     i_net_data = '0;
    logic        i_net_data_val = 1'b0;
    packet_t     o_rx_data;
    logic        o_rx_data_val;
    logic [15:0] o_tx_count;
    logic [15:0] o_rx_count;
    logic        o_overflow;
`ifdef PE_NET_IF_STALL_CNT_EN
    logic [15:0] o_stall_count;
`endif

    int      n_cmp = 0;
    int      n_bad = 0;
    packet_t tx_q[$];
    packet_t rx_q[$];

    always #5 clk = ~clk;

    pe_net_if #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pe_data      (i_pe_data),
        .i_pe_data_val  (i_pe_data_val),
        .o_pe_ready     (o_pe_ready),
        .o_net_data     (o_net_data),
        .o_net_data_val (o_net_data_val),
        .i_net_en       (i_net_en),
        .i_net_data     (i_net_data),
        .i_net_data_val (i_net_data_val),
        .o_rx_data      (o_rx_data),
        .o_rx_data_val  (o_rx_data_val),
        .o_tx_count     (o_tx_count),
        .o_rx_count     (o_rx_count),
`ifdef PE_NET_IF_STALL_CNT_EN
        .o_stall_count  (o_stall_count),
`endif
        .o_overflow     (o_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        i_pe_data_val  = 1'b0;
        i_net_en       = 4'b0000;
        i_net_data_val = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a valid output.
    initial forever begin
        @(negedge clk);
        if (reset_n && o_net_data_val) begin
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got packet %0h expected no packet", o_net_data);
            end else begin
                check("tx_data", 64'(o_net_data), 64'(tx_q.pop_front()));
            end
        end
        if (reset_n && o_rx_data_val) begin
            if (rx_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got packet %0h expected no packet", o_rx_data);
            end else begin
                check("rx_data", 64'(o_rx_data), 64'(rx_q.pop_front()));
            end
        end
    end

    initial begin
        packet_t pa [3];
        pa[0] = 32'hA000_0001; pa[1] = 32'hB000_0002; pa[2] = 32'hC000_0003;

        // Reset state
        do_reset();
        check("rst_pe_ready", 64'(o_pe_ready), 64'd1);
        check("rst_net_val", 64'(o_net_data_val), 64'd0);
        check("rst_net_data", 64'(o_net_data), 64'd0);
        check("rst_rx_val", 64'(o_rx_data_val), 64'd0);
        check("rst_counts", {32'(o_tx_count), 32'(o_rx_count)}, 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);

        // A, B, C back to back with router enabled; 2-cycle latency
        i_net_en = 4'b0001;
        i_pe_data_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_pe_data = pa[i];
            tx_q.push_back(pa[i]);
            tick();
            if (i == 0) check("lat_no_bypass", 64'(o_net_data_val), 64'd0);
            if (i == 1) check("lat_a_valid", {31'd0, o_net_data_val, o_net_data}, {32'd1, pa[0]});
        end
        i_pe_data_val = 1'b0;
        repeat (3) tick();
        check("tx_count_3", 64'(o_tx_count), 64'd3);

        // Fill while blocked, overflow on 5th, then drain in order
        i_net_en = 4'b0000;
        i_pe_data_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_pe_data = 32'h5000_0000 + 32'(i);
            tx_q.push_back(i_pe_data);
            tick();
            check("blocked_no_val", 64'(o_net_data_val), 64'd0);
        end
        check("full_not_ready", 64'(o_pe_ready), 64'd0);
        check("pre_overflow", 64'(o_overflow), 64'd0);
        i_pe_data = 32'h5000_0004;
        tick();
        i_pe_data_val = 1'b0;
        check("overflow_set", 64'(o_overflow), 64'd1);
        check("blocked_no_val5", 64'(o_net_data_val), 64'd0);
        i_net_en = 4'b0100;
        repeat (6) tick();
        check("tx_count_7", 64'(o_tx_count), 64'd7);
        check("drain_2", 64'(tx_q.size()), 64'd0);

        // Full FIFO: push and pop in the same cycle
        do_reset();
        i_pe_data_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_pe_data = 32'h6000_0000 + 32'(i);
            tx_q.push_back(i_pe_data);
            tick();
        end
        i_pe_data = 32'h6000_0004;
        i_net_en = 4'b1000;
        tick();
        i_pe_data_val = 1'b0;
        check("pp_overflow", 64'(o_overflow), 64'd1);
        check("pp_ready_cnt3", 64'(o_pe_ready), 64'd1);
        repeat (5) tick();
        check("pp_tx_count", 64'(o_tx_count), 64'd4);
        check("drain_3", 64'(tx_q.size()), 64'd0);

        // Toggled enable: one packet per enabled cycle, order kept
        do_reset();
        i_pe_data_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_pe_data = 32'h7000_0000 + 32'(i);
            tx_q.push_back(i_pe_data);
            tick();
        end
        i_pe_data_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_net_en = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            check("tog_tx_count", 64'(o_tx_count), 64'(i / 2 + 1));
        end
        i_net_en = 4'b0000;
        tick();
        check("drain_4", 64'(tx_q.size()), 64'd0);

        // Ejection path and rx counter wrap
        i_net_data_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_net_data = 32'hD000_0000 + 32'(i);
            rx_q.push_back(i_net_data);
            tick();
            check("rx_latency", 64'(o_rx_data), 64'(32'hD000_0000 + 32'(i)));
        end
        i_net_data_val = 1'b0;
        tick();
        check("rx_count_3", 64'(o_rx_count), 64'd3);
        i_net_data_val = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            i_net_data = 32'(i);
            rx_q.push_back(i_net_data);
            tick();
        end
        i_net_data_val = 1'b0;
        tick();
        check("rx_count_max", 64'(o_rx_count), 64'hFFFF);
        i_net_data_val = 1'b1;
        i_net_data = 32'hEEEE_EEEE;
        rx_q.push_back(i_net_data);
        tick();
        i_net_data_val = 1'b0;
        check("rx_count_wrap", 64'(o_rx_count), 64'd0);
        tick();
        check("rx_drain", 64'(rx_q.size()), 64'd0);

        // Reset mid-burst with entries queued
        do_reset();
        i_pe_data_val = 1'b1;
        i_pe_data = 32'h8000_0000;
        tick();
        i_pe_data = 32'h8000_0001;
        tick();
        i_pe_data_val = 1'b0;
        i_net_en = 4'b0001;
        tx_q.push_back(32'h8000_0000);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_val", 64'(o_net_data_val), 64'd0);
        check("async_rst_data", 64'(o_net_data), 64'd0);
        check("async_rst_tx", 64'(o_tx_count), 64'd0);
        check("async_rst_ready", 64'(o_pe_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("no_stale_tx", 64'(o_tx_count), 64'd0);
        check("drain_6", 64'(tx_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
